// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (port 0)
// and the debug/DMA loader (port 1), and adds a sequenced clear engine that
// zeroes the whole array through ordinary write cycles.
module dmem_arbiter #(
    parameter int unsigned d_width    = 8,
    parameter int unsigned dmem_width = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p0_req,
    input  logic               p0_we,
    input  logic [d_width-1:0] p0_addr,
    input  logic [d_width-1:0] p0_wdata,
    output logic               p0_ack,
    output logic [d_width-1:0] p0_rdata,
    input  logic               p1_req,
    input  logic               p1_we,
    input  logic [d_width-1:0] p1_addr,
    input  logic [d_width-1:0] p1_wdata,
    output logic               p1_ack,
    output logic [d_width-1:0] p1_rdata,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    output logic [d_width-1:0] dmem_alu_result,
    output logic [d_width-1:0] dmem_in,
    output logic               dmem_write_en,
    input  logic [d_width-1:0] dmem_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [d_width-1:0] last_addr = d_width'(dmem_width - 1);

    state_t             state, state_nx;
    logic               stg_valid, stg_valid_nx;
    logic               stg_port, stg_port_nx;
    logic               stg_we, stg_we_nx;
    logic [d_width-1:0] stg_addr, stg_addr_nx;
    logic [d_width-1:0] stg_wdata, stg_wdata_nx;
    logic               last, last_nx;
    logic [d_width-1:0] cnt, cnt_nx;
    logic               done, done_nx;
    logic               elig0, elig1;
    logic               grant, winner;

    // state, grant stage, round-robin pointer and clear counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stg_valid <= 1'b0;
            stg_port  <= 1'b0;
            stg_we    <= 1'b0;
            stg_addr  <= '0;
            stg_wdata <= '0;
            last      <= 1'b1;
            cnt       <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            stg_valid <= stg_valid_nx;
            stg_port  <= stg_port_nx;
            stg_we    <= stg_we_nx;
            stg_addr  <= stg_addr_nx;
            stg_wdata <= stg_wdata_nx;
            last      <= last_nx;
            cnt       <= cnt_nx;
            done      <= done_nx;
        end
    end

    // arbitration, clear sequencing and next-state selection
    always_comb begin
        state_nx     = state;
        stg_valid_nx = 1'b0;
        stg_port_nx  = stg_port;
        stg_we_nx    = stg_we;
        stg_addr_nx  = stg_addr;
        stg_wdata_nx = stg_wdata;
        last_nx      = last;
        cnt_nx       = cnt;
        done_nx      = 1'b0;

        // a port completing this cycle is masked so it cannot be re-granted
        elig0  = p0_req & ~p0_ack;
        elig1  = p1_req & ~p1_ack;
        grant  = elig0 | elig1;
        winner = (elig0 & elig1) ? ~last : elig1;

        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                    grant    = 1'b0;
                end
            end
            CLEAR: begin
                // arbitration is allowed on the final clear edge so the
                // first port ack lines up with the clr_done pulse
                if (cnt == last_addr) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    grant  = 1'b0;
                end
            end
            default: grant = 1'b0;
        endcase

        if (grant) begin
            stg_valid_nx = 1'b1;
            stg_port_nx  = winner;
            stg_we_nx    = winner ? p1_we : p0_we;
            stg_addr_nx  = winner ? p1_addr : p0_addr;
            stg_wdata_nx = winner ? p1_wdata : p0_wdata;
            last_nx      = winner;
        end
    end

    // memory pins and requester responses
    always_comb begin
        dmem_alu_result = '0;
        dmem_in         = '0;
        dmem_write_en   = 1'b0;
        clr_busy        = 1'b0;
        p0_ack          = 1'b0;
        p1_ack          = 1'b0;
        p0_rdata        = '0;
        p1_rdata        = '0;
        if (state == CLEAR) begin
            dmem_alu_result = cnt;
            dmem_write_en   = 1'b1;
            clr_busy        = 1'b1;
        end else if (stg_valid) begin
            dmem_alu_result = stg_addr;
            dmem_in         = stg_wdata;
            dmem_write_en   = stg_we;
            if (stg_port) begin
                p1_ack = 1'b1;
                if (!stg_we) p1_rdata = dmem_out;
            end else begin
                p0_ack = 1'b1;
                if (!stg_we) p0_rdata = dmem_out;
            end
        end
    end

    assign clr_done = done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test-plan scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [DW-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic [DW-1:0] dmem_alu_result, dmem_in, dmem_out;
    logic          dmem_write_en;

    dmem_arbiter #(.d_width(DW), .dmem_width(NW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .dmem_alu_result(dmem_alu_result), .dmem_in(dmem_in),
        .dmem_write_en(dmem_write_en), .dmem_out(dmem_out)
    );

    always #5 clk = ~clk;

    // the data memory the arbiter drives
    logic [DW-1:0] mem [NW];
    assign dmem_out = mem[dmem_alu_result];
    always @(posedge clk) if (dmem_write_en) mem[dmem_alu_result] <= dmem_in;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [NW];
    int            clear_left = 0;   // clear writes still to issue
    bit            pv = 0, pport = 0, pwe = 0;
    logic [DW-1:0] paddr = '0, pwd = '0;
    bit            mlast = 1, mdone = 0;

    bit            q_rst, q_r0, q_r1, q_w0, q_w1, q_clr;
    logic [DW-1:0] q_a0, q_a1, q_d0, q_d1;

    bit            e_ack0, e_ack1, e_we, e_busy, e_done;
    logic [DW-1:0] e_rd0, e_rd1, e_addr, e_din;

    task automatic arbitrate(input bit el0, input bit el1);
        bit w;
        if (el0 || el1) begin
            w     = (el0 && el1) ? !mlast : el1;
            pv    = 1;
            pport = w;
            pwe   = w ? q_w1 : q_w0;
            paddr = w ? q_a1 : q_a0;
            pwd   = w ? q_d1 : q_d0;
            mlast = w;
        end
    endtask

    task automatic model_update();
        bit el0, el1;
        // memory effect of the cycle that just ended
        if (clear_left > 0) ref_mem[NW - clear_left] = '0;
        else if (pv && pwe) ref_mem[paddr] = pwd;
        el0 = q_r0 && !(pv && !pport);
        el1 = q_r1 && !(pv && pport);
        pv = 0;
        if (q_rst) begin
            clear_left = 0; mlast = 1; mdone = 0;
        end else if (clear_left > 0) begin
            clear_left--;
            mdone = (clear_left == 0);
            if (clear_left == 0) arbitrate(el0, el1);
        end else begin
            mdone = 0;
            if (q_clr) clear_left = NW;
            else arbitrate(el0, el1);
        end
        // expected outputs for the cycle now starting
        e_ack0 = 0; e_ack1 = 0; e_rd0 = '0; e_rd1 = '0;
        e_addr = '0; e_din = '0; e_we = 0; e_busy = 0; e_done = mdone;
        if (clear_left > 0) begin
            e_addr = DW'(NW - clear_left); e_we = 1; e_busy = 1;
        end else if (pv) begin
            e_addr = paddr; e_din = pwd; e_we = pwe;
            if (pport) begin e_ack1 = 1; e_rd1 = pwe ? '0 : ref_mem[paddr]; end
            else       begin e_ack0 = 1; e_rd0 = pwe ? '0 : ref_mem[paddr]; end
        end
    endtask

    task automatic compare_all();
        check("ack0", p0_ack, e_ack0);
        check("ack1", p1_ack, e_ack1);
        check("rdata0", p0_rdata, e_rd0);
        check("rdata1", p1_rdata, e_rd1);
        check("addr", dmem_alu_result, e_addr);
        check("din", dmem_in, e_din);
        check("we", dmem_write_en, e_we);
        check("busy", clr_busy, e_busy);
        check("done", clr_done, e_done);
    endtask

    // one clock: latch the applied inputs, step the model, compare
    task automatic tick();
        q_rst = reset; q_clr = clr_start;
        q_r0 = p0_req; q_w0 = p0_we; q_a0 = p0_addr; q_d0 = p0_wdata;
        q_r1 = p1_req; q_w1 = p1_we; q_a1 = p1_addr; q_d1 = p1_wdata;
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic xfer(input bit port, input bit we, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd);
        bit got = 0;
        rd = '0;
        if (port) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
        else      begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (port ? e_ack1 : e_ack0) begin
                got = 1;
                rd  = port ? p1_rdata : p0_rdata;
            end
        end
        if (port) p1_req = 0; else p0_req = 0;
        if (!got) check("xfer_timeout", 1, 0);
    endtask

    // entered in the first clear cycle; leaves in the cycle after the clear
    task automatic run_clear(input int repulse, output int busy_cycles);
        busy_cycles = 0;
        while (e_busy && busy_cycles < 300) begin
            check("clr_addr_order", dmem_alu_result, busy_cycles);
            check("clr_p0_blocked", p0_ack, 0);
            clr_start = (busy_cycles == repulse);
            busy_cycles++;
            tick();
        end
        clr_start = 0;
    endtask

    function automatic logic [DW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return DW'($urandom);
        return DW'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [DW-1:0] rd;
        int nb;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        reset = 1; clr_start = 0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        tick(); tick();
        reset = 0;
        check("rst_busy", clr_busy, 0);
        check("rst_done", clr_done, 0);
        check("rst_addr", dmem_alu_result, 0);
        check("rst_we", dmem_write_en, 0);

        // wipe so memory contents are known
        clr_start = 1; tick(); clr_start = 0;
        run_clear(-1, nb);
        check("wipe_len", nb, NW);

        // single write then read on port 0
        p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 8'h5A;
        check("t1_no_early_ack", p0_ack, 0);
        tick();
        check("t1_wr_ack", p0_ack, 1);
        check("t1_wr_we", dmem_write_en, 1);
        check("t1_wr_addr", dmem_alu_result, 8'h10);
        p0_we = 0;
        tick();
        check("t1_gap_ack", p0_ack, 0);
        check("t1_gap_we", dmem_write_en, 0);
        tick();
        check("t1_rd_ack", p0_ack, 1);
        check("t1_rd_we", dmem_write_en, 0);
        check("t1_rdata", p0_rdata, 8'h5A);
        p0_req = 0;
        tick();

        // contention from reset
        reset = 1;
        p0_req = 1; p0_we = 0; p0_addr = 8'h01;
        p1_req = 1; p1_we = 0; p1_addr = 8'h02;
        tick();
        reset = 0;
        check("t2_post_rst_ack0", p0_ack, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t2_alt_ack0", p0_ack, (i % 2) == 0);
            check("t2_alt_ack1", p1_ack, (i % 2) == 1);
            tick();
        end
        p0_req = 0; p1_req = 0;
        tick(); tick();

        // single-port hold on port 1
        p1_req = 1; p1_we = 0; p1_addr = 8'h03;
        for (int i = 0; i < 6; i++) begin
            check("t3_p1_ack", p1_ack, (i % 2) == 1);
            tick();
        end
        p1_req = 0;
        tick(); tick();

        // full clear with port 0 waiting
        xfer(1, 1, 8'h00, 8'h11, rd);
        xfer(1, 1, 8'h80, 8'h22, rd);
        xfer(1, 1, 8'hFF, 8'h33, rd);
        tick();
        p0_req = 1; p0_we = 0; p0_addr = 8'h80;
        clr_start = 1;
        tick();
        clr_start = 0;
        run_clear(-1, nb);
        check("t4_busy_len", nb, NW);
        check("t4_done", clr_done, 1);
        check("t4_p0_ack_at_done", p0_ack, 1);
        check("t4_rd80", p0_rdata, 0);
        p0_req = 0;
        tick();
        check("t4_done_one_cycle", clr_done, 0);
        xfer(0, 0, 8'h00, 8'h00, rd); check("t4_rd00", rd, 0);
        xfer(0, 0, 8'hFF, 8'h00, rd); check("t4_rdFF", rd, 0);
        tick();

        // clr_start alongside a valid stage, plus a re-pulse mid-clear
        p0_req = 1; p0_we = 1; p0_addr = 8'h20; p0_wdata = 8'h77;
        tick();
        check("t5_ack_with_clr", p0_ack, 1);
        check("t5_wr_with_clr", dmem_write_en, 1);
        p0_req = 0; clr_start = 1;
        tick();
        clr_start = 0;
        check("t5_clear_next", clr_busy, 1);
        run_clear(10, nb);
        check("t5_busy_len_repulse", nb, NW);
        tick();

        // reset in the middle of a clear
        xfer(1, 1, 8'd150, 8'h44, rd);
        tick();
        clr_start = 1; tick(); clr_start = 0;
        for (int i = 0; i < 100; i++) tick();
        check("t6_cnt100", dmem_alu_result, 100);
        reset = 1;
        tick();
        reset = 0;
        check("t6_busy", clr_busy, 0);
        check("t6_addr", dmem_alu_result, 0);
        check("t6_we", dmem_write_en, 0);
        check("t6_done", clr_done, 0);
        tick();
        check("t6_no_done", clr_done, 0);
        xfer(0, 0, 8'd150, 8'h00, rd);
        check("t6_rd150_kept", rd, 8'h44);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!p0_req || e_ack0) begin
                p0_req = ($urandom_range(0, 9) < 6);
                p0_we = 1'($urandom_range(0, 1));
                p0_addr = rand_addr(); p0_wdata = DW'($urandom);
            end
            if (!p1_req || e_ack1) begin
                p1_req = ($urandom_range(0, 9) < 6);
                p1_we = 1'($urandom_range(0, 1));
                p1_addr = rand_addr(); p1_wdata = DW'($urandom);
            end
            clr_start = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0; clr_start = 0; p0_req = 0; p1_req = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
